// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side handshake plus decoded bundle for the execute stage.
interface decode_stage_if #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned REG_AW  = 2,
  parameter int unsigned IMM_W   = 8
);
  localparam int unsigned ALU_W = 3;
  localparam int unsigned CNT_W = 16;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic               out_valid;
  logic               out_ready;
  logic [OP_W-1:0]    opcode;
  logic [REG_AW-1:0]  rs_addr;
  logic [REG_AW-1:0]  rt_addr;
  logic [REG_AW-1:0]  dst_addr;
  logic [IMM_W-1:0]   immediate;
  logic               reg_write;
  logic               mem_write;
  logic               mem_to_reg;
  logic               alu_src1;
  logic               alu_src2;
  logic [ALU_W-1:0]   alu_op;
  logic               illegal;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   illegal_cnt;

  // Upstream/downstream side: drives instructions and consumes bundles
  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, opcode, rs_addr, rt_addr, dst_addr, immediate,
           reg_write, mem_write, mem_to_reg, alu_src1, alu_src2, alu_op, illegal,
           stall_cnt, illegal_cnt
  );

  // Decode stage side
  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, opcode, rs_addr, rt_addr, dst_addr, immediate,
           reg_write, mem_write, mem_to_reg, alu_src1, alu_src2, alu_op, illegal,
           stall_cnt, illegal_cnt
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder with valid/ready handshake,
// one-bubble load-use interlock, flush and illegal-opcode flagging.
// Optional macro DECODE_PERF_CNT_EN builds saturating stall/illegal counters.
module decode_stage #(
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned REG_AW  = 2,
  parameter int unsigned IMM_W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  decode_stage_if.slave bus
);
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned RS_LSB = INSTR_W - OP_W - REG_AW;
  localparam int unsigned RT_LSB = RS_LSB - REG_AW;
  localparam int unsigned RD_LSB = RT_LSB - REG_AW;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  typedef struct packed {
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src1;
    logic             alu_src2;
    logic [ALU_W-1:0] alu_op;
    logic             mem_write;
    logic             mem_to_reg;
    logic             uses_rs;
    logic             uses_rt;
    logic             illegal;
  } ctrl_t;

  function automatic ctrl_t row(input logic rdst, input logic rw, input logic s1,
                                input logic s2, input logic [ALU_W-1:0] aop,
                                input logic mw, input logic m2r,
                                input logic urs, input logic urt);
    ctrl_t c;
    c.reg_dst    = rdst;
    c.reg_write  = rw;
    c.alu_src1   = s1;
    c.alu_src2   = s2;
    c.alu_op     = aop;
    c.mem_write  = mw;
    c.mem_to_reg = m2r;
    c.uses_rs    = urs;
    c.uses_rt    = urt;
    c.illegal    = 1'b0;
    return c;
  endfunction

  state_t             r_state;
  state_t             w_state_nxt;
  logic [OP_W-1:0]    w_op;
  logic [REG_AW-1:0]  w_rs;
  logic [REG_AW-1:0]  w_rt;
  logic [REG_AW-1:0]  w_rd;
  ctrl_t              w_ctrl;
  logic               w_hazard;
  logic               w_in_ready;
  logic               w_fire;

  logic [OP_W-1:0]    r_opcode;
  logic [REG_AW-1:0]  r_rs;
  logic [REG_AW-1:0]  r_rt;
  logic [REG_AW-1:0]  r_dst;
  logic [IMM_W-1:0]   r_imm;
  logic               r_reg_write;
  logic               r_mem_write;
  logic               r_mem_to_reg;
  logic               r_alu_src1;
  logic               r_alu_src2;
  logic [ALU_W-1:0]   r_alu_op;
  logic               r_illegal;

  assign w_op = bus.instr[INSTR_W-1 -: OP_W];
  assign w_rs = bus.instr[RS_LSB +: REG_AW];
  assign w_rt = bus.instr[RT_LSB +: REG_AW];
  assign w_rd = bus.instr[RD_LSB +: REG_AW];

  // Control table lookup; unlisted opcodes decode to an illegal NOP
  always_comb begin
    w_ctrl         = '0;
    w_ctrl.illegal = 1'b1;
    case (w_op)
      OP_W'(0):  w_ctrl = row(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      OP_W'(1):  w_ctrl = row(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      OP_W'(2):  w_ctrl = row(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_W'(3):  w_ctrl = row(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_W'(4):  w_ctrl = row(1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_W'(5):  w_ctrl = row(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_W'(6):  w_ctrl = row(1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_W'(7):  w_ctrl = row(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_W'(8):  w_ctrl = row(1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_W'(9):  w_ctrl = row(1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_W'(10): w_ctrl = row(1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
      OP_W'(11): w_ctrl = row(1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_W'(12): w_ctrl = row(1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1);
      OP_W'(13): w_ctrl = row(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      default:   ;
    endcase
  end

  // Output-register occupancy state
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next occupancy: flush empties, a load fills, a drained bundle empties
  always_comb begin
    w_state_nxt = r_state;
    if (flush)                                      w_state_nxt = S_EMPTY;
    else if (w_fire)                                w_state_nxt = S_FULL;
    else if ((r_state == S_FULL) && bus.out_ready)  w_state_nxt = S_EMPTY;
  end

  // Load-use interlock against the bundle currently held, and the input handshake
  always_comb begin
    w_hazard   = 1'b0;
    w_in_ready = 1'b0;
    w_fire     = 1'b0;
    w_hazard   = (r_state == S_FULL) & r_mem_to_reg & r_reg_write & bus.in_valid &
                 ((w_ctrl.uses_rs & (w_rs == r_dst)) | (w_ctrl.uses_rt & (w_rt == r_dst)));
    w_in_ready = ((r_state == S_EMPTY) | bus.out_ready) & ~w_hazard & ~flush;
    w_fire     = bus.in_valid & w_in_ready;
  end

  // Bundle register: captures the decoded fields on every accepted instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opcode     <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_dst        <= '0;
      r_imm        <= '0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_alu_src1   <= 1'b0;
      r_alu_src2   <= 1'b0;
      r_alu_op     <= '0;
      r_illegal    <= 1'b0;
    end else if (w_fire) begin
      r_opcode     <= w_op;
      r_rs         <= w_rs;
      r_rt         <= w_rt;
      r_dst        <= w_ctrl.reg_dst ? w_rd : w_rt;
      r_imm        <= bus.instr[IMM_W-1:0];
      r_reg_write  <= w_ctrl.reg_write;
      r_mem_write  <= w_ctrl.mem_write;
      r_mem_to_reg <= w_ctrl.mem_to_reg;
      r_alu_src1   <= w_ctrl.alu_src1;
      r_alu_src2   <= w_ctrl.alu_src2;
      r_alu_op     <= w_ctrl.alu_op;
      r_illegal    <= w_ctrl.illegal;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = (r_state == S_FULL);
  assign bus.opcode     = r_opcode;
  assign bus.rs_addr    = r_rs;
  assign bus.rt_addr    = r_rt;
  assign bus.dst_addr   = r_dst;
  assign bus.immediate  = r_imm;
  assign bus.reg_write  = r_reg_write;
  assign bus.mem_write  = r_mem_write;
  assign bus.mem_to_reg = r_mem_to_reg;
  assign bus.alu_src1   = r_alu_src1;
  assign bus.alu_src2   = r_alu_src2;
  assign bus.alu_op     = r_alu_op;
  assign bus.illegal    = r_illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_illegal_cnt;

  // Saturating counters of interlock cycles and accepted illegal opcodes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt   <= '0;
      r_illegal_cnt <= '0;
    end else begin
      if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_fire && w_ctrl.illegal && (r_illegal_cnt != {CNT_W{1'b1}}))
        r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.illegal_cnt = r_illegal_cnt;
`else
  assign bus.stall_cnt   = '0;
  assign bus.illegal_cnt = '0;
`endif

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Parametrised, registered successor to the combinational instruction decoder. Accepts one instruction per cycle over a valid/ready handshake and splits it into fields and control signals. Holds the result in an output pipeline register for the execute stage, with a one-bubble load-use interlock, flush, and illegal-opcode detection. Sits between the fetch/instruction-memory stage and the register-file read/execute stage.

Parameters:
INSTR_W, 16, instruction width in bits
OP_W, 4, opcode width; opcode = instr[INSTR_W-1 -: OP_W]
REG_AW, 2, register address width; rs, rt, rd follow the opcode in that order, MSB first
IMM_W, 8, immediate width; imm = instr[IMM_W-1:0], zero-extended to IMM_W (no sign extension)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  synchronous active-low reset
flush  in  1  discard output register and any interlock this cycle
in_valid  in  1  instr is valid
in_ready  out  1  stage accepts instr this cycle
instr  in  INSTR_W  instruction word
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
opcode  out  OP_W  registered opcode
rs_addr, rt_addr  out  REG_AW each  registered source addresses
dst_addr  out  REG_AW  RegDst ? rd : rt
immediate  out  IMM_W  registered immediate
reg_write, mem_write, mem_to_reg, alu_src1, alu_src2  out  1 each  registered controls
alu_op  out  3  registered ALU operation
illegal  out  1  bundle came from an undefined opcode
stall_cnt, illegal_cnt  out  16 each  performance counters (see Optional Feature)

Behaviour:
- Control table, listed as RegDst RegWrite ALUSrc1 ALUSrc2 ALUOp MemWrite MemToReg | uses_rs uses_rt:
  - 0 LW: 0 1 0 1 000 0 1 | 1 0
  - 1 SW: 0 0 0 0 000 1 0 | 1 1
  - 2 ADD: 1 1 0 0 000 0 0 | 1 1
  - 3 ADDI: 0 1 0 1 000 0 0 | 1 0
  - 4 INV: 1 1 0 0 001 0 0 | 1 0
  - 5 AND: 1 1 0 0 010 0 0 | 1 1
  - 6 ANDI: 0 1 0 1 010 0 0 | 1 0
  - 7 OR: 1 1 0 0 011 0 0 | 1 1
  - 8 ORI: 0 1 0 1 011 0 0 | 1 0
  - 9 SRA: 0 1 0 0 100 0 0 | 1 0
  - 10 SLL: 0 1 0 0 101 0 0 | 1 0
  - 11 BEQ: 0 0 0 0 110 0 0 | 1 1
  - 12 BNE: 0 0 0 0 111 0 0 | 1 1
  - 13 CLR: 1 1 1 0 010 0 0 | 0 0
- Any other opcode: all controls 0, uses_rs = uses_rt = 0, illegal = 1 (architectural NOP). When OP_W > 4, only the values listed above are legal.
- Reset (rst_n = 0 at an edge): out_valid = 0; every registered output = 0; counters = 0. Reset overrides flush and the handshake. Reset mid-stall drops the interlock; in_ready follows its combinational rule from the next cycle.
- Output register states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
- Load: a new bundle is loaded when in_valid & in_ready. Latency from instr to the registered outputs is 1 cycle.
- Hazard: hazard = out_valid & out mem_to_reg & out reg_write & in_valid & ((uses_rs(instr) & rs == out dst_addr) | (uses_rt(instr) & rt == out dst_addr)).
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush. This is combinational; it never depends on in_valid except through hazard.
- Hazard & out_ready: the LW bundle leaves, out_valid -> 0 (one bubble) and the instruction stays upstream. Next cycle the stage is EMPTY and accepts it.
- Hazard & ~out_ready: hold all registers.
- FULL & out_ready & ~in_fire: out_valid -> 0.
- FULL & ~out_ready: hold all registered outputs stable.
- flush: out_valid -> 0 next cycle and nothing is accepted. Flush has priority over load and hazard.
- out_valid is never deasserted without out_ready, except on flush or reset.

Optional Feature:
- Macro: DECODE_PERF_CNT_EN.
- Defined: stall_cnt increments on every cycle with hazard = 1. illegal_cnt increments on every accepted instruction whose opcode is illegal. Both saturate at 16'hFFFF and clear only on reset.
- Undefined: both ports are tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset: hold rst_n = 0 two cycles with in_valid = 1 -> out_valid = 0, all outputs 0. After release, instr 16'h2480 (ADD rs=1 rt=0 rd=2) -> next cycle out_valid = 1, dst_addr = 2, reg_write = 1, alu_op = 000.
- Load-use: 16'h0104 (LW rt=1, imm=4), then 16'h2480 with out_ready = 1 -> LW out, one bubble (out_valid = 0, in_ready = 0 that cycle), ADD out next cycle. stall_cnt = 1 if the macro is enabled.
- No false hazard: LW 16'h0104, then 16'h3A05 (ADDI rs=2 rt=2) -> back-to-back, no bubble. Same result for CLR 16'hD580 after LW.
- Backpressure: out_ready = 0 for 3 cycles with FULL and in_valid = 1 -> in_ready = 0, outputs unchanged. Raise out_ready -> the next instruction loads in that cycle.
- Flush and illegal: flush while FULL -> out_valid = 0 next cycle, no instruction accepted. Then 16'hE123 -> illegal = 1, reg_write = mem_write = 0, illegal_cnt = 1 if the macro is enabled.
